// File: rtl/vga_sprite_compositor.sv
// VGA timing plus sprite compositor: N pipes with gaps and a signed-coordinate bird box,
// drawn from per-frame shadow copies through a 2-stage pipeline, with a per-frame collision flag.
module vga_sprite_compositor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int N_PIPES  = 4,
  parameter int PIPE_W   = 80,
  parameter int GAP_H    = 100,
  parameter int BIRD_R   = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10*N_PIPES-1:0]  pipe_x,
  input  logic [10*N_PIPES-1:0]  pipe_gap_y,
  input  logic [N_PIPES-1:0]     pipe_valid,
  input  logic [9:0]             bird_x,
  input  logic [9:0]             bird_y,
  output logic                   vga_h_sync,
  output logic                   vga_v_sync,
  output logic                   vga_r,
  output logic                   vga_g,
  output logic                   vga_b,
  output logic                   frame_start,
  output logic                   collide,
  output logic                   collide_vld
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [10:0]        PIPE_W11 = 11'(PIPE_W);
  localparam logic [10:0]        GAP_H11  = 11'(GAP_H);
  localparam logic signed [11:0] BIRD_R12 = 12'(BIRD_R);

  // stage 0: raster counters
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  // per-frame shadow copies of the game object positions
  logic [N_PIPES-1:0][9:0] sh_px_q, sh_px_d;
  logic [N_PIPES-1:0][9:0] sh_gy_q, sh_gy_d;
  logic [N_PIPES-1:0]      sh_valid_q, sh_valid_d;
  logic [9:0]              sh_bx_q, sh_bx_d;
  logic [9:0]              sh_by_q, sh_by_d;

  // stage 1 registers
  logic [N_PIPES-1:0] pipe_hit_q, pipe_hit_d;
  logic               bird_hit_q, bird_hit_d;
  logic               active_q, active_d;
  logic               s1_hsync_q, s1_hsync_d;
  logic               s1_vsync_q, s1_vsync_d;

  // stage 2 registers (pins)
  logic red_q, red_d;
  logic green_q, green_d;
  logic blue_q, blue_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;

  // frame bookkeeping
  logic acc_q, acc_d;
  logic collide_q, collide_d;
  logic collide_vld_q, collide_vld_d;
  logic frame_start_q, frame_start_d;

  logic snap;
  logic snap_next;
  logic frame_hit;

  logic [10:0]        x11;
  logic [10:0]        y11;
  logic signed [11:0] dx;
  logic signed [11:0] dy;

  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
    end
  end

  // snap_next lets the frame pulses come out of flops exactly during the snapshot cycle
  assign snap      = (hcnt_q == '0) && (vcnt_q == V_ACT);
  assign snap_next = (hcnt_q == H_LAST) && (vcnt_q == V_ACT_LAST);

  always_comb begin
    sh_px_d    = sh_px_q;
    sh_gy_d    = sh_gy_q;
    sh_valid_d = sh_valid_q;
    sh_bx_d    = sh_bx_q;
    sh_by_d    = sh_by_q;
    if (snap) begin
      for (int i = 0; i < N_PIPES; i++) begin
        sh_px_d[i] = pipe_x[10*i +: 10];
        sh_gy_d[i] = pipe_gap_y[10*i +: 10];
      end
      sh_valid_d = pipe_valid;
      sh_bx_d    = bird_x;
      sh_by_d    = bird_y;
    end
  end

  // 11-bit pipe bounds cannot wrap, so a pipe near x=1023 never reappears at column 0
  assign x11 = {1'b0, hcnt_q};
  assign y11 = {1'b0, vcnt_q};
  assign dx  = $signed({2'b00, hcnt_q}) - $signed({{2{sh_bx_q[9]}}, sh_bx_q});
  assign dy  = $signed({2'b00, vcnt_q}) - $signed({{2{sh_by_q[9]}}, sh_by_q});

  always_comb begin
    pipe_hit_d = '0;
    for (int i = 0; i < N_PIPES; i++) begin
      pipe_hit_d[i] = sh_valid_q[i]
                   && (x11 >= {1'b0, sh_px_q[i]})
                   && (x11 <  ({1'b0, sh_px_q[i]} + PIPE_W11))
                   && !((y11 >= {1'b0, sh_gy_q[i]}) && (y11 < ({1'b0, sh_gy_q[i]} + GAP_H11)));
    end
    bird_hit_d = (dx >= -BIRD_R12) && (dx <= BIRD_R12) && (dy >= -BIRD_R12) && (dy <= BIRD_R12);
    active_d   = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    s1_hsync_d = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
    s1_vsync_d = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
  end

  always_comb begin
    red_d   = active_q && bird_hit_q;
    green_d = active_q && !bird_hit_q && (|pipe_hit_q);
    blue_d  = 1'b0;
    hsync_d = s1_hsync_q;
    vsync_d = s1_vsync_q;
  end

  // only visible overlaps count, so what the player sees is exactly what is reported
  assign frame_hit = active_q && bird_hit_q && (|pipe_hit_q);

  always_comb begin
    acc_d         = acc_q | frame_hit;
    collide_d     = collide_q;
    collide_vld_d = snap_next;
    frame_start_d = snap_next;
    if (snap_next) begin
      collide_d = acc_q | frame_hit;
      acc_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      sh_px_q       <= '0;
      sh_gy_q       <= '0;
      sh_valid_q    <= '0;
      sh_bx_q       <= '0;
      sh_by_q       <= '0;
      pipe_hit_q    <= '0;
      bird_hit_q    <= 1'b0;
      active_q      <= 1'b0;
      s1_hsync_q    <= 1'b1;
      s1_vsync_q    <= 1'b1;
      red_q         <= 1'b0;
      green_q       <= 1'b0;
      blue_q        <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      acc_q         <= 1'b0;
      collide_q     <= 1'b0;
      collide_vld_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      sh_px_q       <= sh_px_d;
      sh_gy_q       <= sh_gy_d;
      sh_valid_q    <= sh_valid_d;
      sh_bx_q       <= sh_bx_d;
      sh_by_q       <= sh_by_d;
      pipe_hit_q    <= pipe_hit_d;
      bird_hit_q    <= bird_hit_d;
      active_q      <= active_d;
      s1_hsync_q    <= s1_hsync_d;
      s1_vsync_q    <= s1_vsync_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      acc_q         <= acc_d;
      collide_q     <= collide_d;
      collide_vld_q <= collide_vld_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga_h_sync  = hsync_q;
  assign vga_v_sync  = vsync_q;
  assign vga_r       = red_q;
  assign vga_g       = green_q;
  assign vga_b       = blue_q;
  assign frame_start = frame_start_q;
  assign collide     = collide_q;
  assign collide_vld = collide_vld_q;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Bench for vga_sprite_compositor on a shrunken raster: every cycle's pins are compared
// against a pixel-rule model driven by the positions captured at each frame's snapshot.
module tb_vga_sprite_compositor;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VS = 2, VBP = 3;
  localparam int NP = 4, PW = 16, GH = 12, BR = 3;
  localparam int HT   = HA + HFP + HS + HBP;
  localparam int VT   = VA + VFP + VS + VBP;
  localparam int FT   = HT * VT;
  localparam int SNAP = VA * HT;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [10*NP-1:0] pipe_x = '0;
  logic [10*NP-1:0] pipe_gap_y = '0;
  logic [NP-1:0]    pipe_valid = '0;
  logic [9:0]       bird_x = '0;
  logic [9:0]       bird_y = '0;
  logic vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b;
  logic frame_start, collide, collide_vld;

  vga_sprite_compositor #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .N_PIPES(NP), .PIPE_W(PW), .GAP_H(GH), .BIRD_R(BR)
  ) dut (
    .clk(clk), .reset(reset),
    .pipe_x(pipe_x), .pipe_gap_y(pipe_gap_y), .pipe_valid(pipe_valid),
    .bird_x(bird_x), .bird_y(bird_y),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .collide(collide), .collide_vld(collide_vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // scene presented on the snapshot cycle, and the model's copy of what was captured
  int sc_px[NP], sc_gy[NP], sc_bx, sc_by;
  bit sc_v[NP];
  int sh_px[NP], sh_gy[NP], sh_bx, sh_by;
  bit sh_v[NP];
  bit acc, exp_collide;

  function automatic bit birdAt(int x, int y);
    return (x - sh_bx <= BR) && (sh_bx - x <= BR) && (y - sh_by <= BR) && (sh_by - y <= BR);
  endfunction

  function automatic bit pipeAt(int x, int y);
    for (int i = 0; i < NP; i++)
      if (sh_v[i] && x >= sh_px[i] && x < sh_px[i] + PW && !(y >= sh_gy[i] && y < sh_gy[i] + GH))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(string tag, logic observed, logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, observed, expected);
    end
  endtask

  // off the snapshot cycle the inputs are garbage, which the design must ignore
  task automatic applyStimulus(bit at_snap);
    for (int i = 0; i < NP; i++) begin
      pipe_x[10*i +: 10]     = at_snap ? 10'(sc_px[i]) : 10'($urandom);
      pipe_gap_y[10*i +: 10] = at_snap ? 10'(sc_gy[i]) : 10'($urandom);
      pipe_valid[i]          = at_snap ? sc_v[i] : 1'($urandom);
    end
    bird_x = at_snap ? 10'(sc_bx) : 10'($urandom);
    bird_y = at_snap ? 10'(sc_by) : 10'($urandom);
    if (at_snap) begin
      for (int i = 0; i < NP; i++) begin
        sh_px[i] = sc_px[i];
        sh_gy[i] = sc_gy[i];
        sh_v[i]  = sc_v[i];
      end
      sh_bx = sc_bx;
      sh_by = sc_by;
    end
  endtask

  // called at the falling edge of cycle cyc; the pins show the pixel from two cycles earlier
  task automatic doStep();
    int x, y;
    bit act, snap_now, exp_r, exp_g, exp_hs, exp_vs;
    exp_r = 1'b0; exp_g = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
    if (cyc >= 2) begin
      x = (cyc - 2) % HT;
      y = ((cyc - 2) / HT) % VT;
      act = (x < HA) && (y < VA);
      exp_r = act && birdAt(x, y);
      exp_g = act && !exp_r && pipeAt(x, y);
      if (act && birdAt(x, y) && pipeAt(x, y)) acc = 1'b1;
      exp_hs = !(x >= HA + HFP && x < HA + HFP + HS);
      exp_vs = !(y >= VA + VFP && y < VA + VFP + VS);
    end
    checkOutput("red", vga_r, exp_r);
    checkOutput("green", vga_g, exp_g);
    checkOutput("blue", vga_b, 1'b0);
    checkOutput("hsync", vga_h_sync, exp_hs);
    checkOutput("vsync", vga_v_sync, exp_vs);
    snap_now = (cyc % FT) == SNAP;
    checkOutput("frame_start", frame_start, snap_now);
    checkOutput("collide_vld", collide_vld, snap_now);
    if (snap_now) begin
      exp_collide = acc;
      acc = 1'b0;
    end
    checkOutput("collide", collide, exp_collide);
    applyStimulus(snap_now);
    cyc++;
  endtask

  task automatic runCycles(int count);
    repeat (count) begin
      @(negedge clk);
      doStep();
    end
  endtask

  task automatic resetDut(int len);
    reset = 1'b1;
    repeat (len) begin
      @(negedge clk);
      checkOutput("rst_rgb", vga_r | vga_g | vga_b, 1'b0);
      checkOutput("rst_hsync", vga_h_sync, 1'b1);
      checkOutput("rst_vsync", vga_v_sync, 1'b1);
      checkOutput("rst_pulses", frame_start | collide_vld | collide, 1'b0);
      applyStimulus(1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < NP; i++) begin
      sh_px[i] = 0; sh_gy[i] = 0; sh_v[i] = 1'b0;
    end
    sh_bx = 0; sh_by = 0;
    acc = 1'b0; exp_collide = 1'b0; cyc = 0;
    doStep();
  endtask

  task automatic clearScene();
    for (int i = 0; i < NP; i++) begin
      sc_px[i] = 0; sc_gy[i] = 0; sc_v[i] = 1'b0;
    end
    sc_bx = -50; sc_by = -50;
  endtask

  task automatic randomScene();
    for (int i = 0; i < NP; i++) begin
      sc_px[i] = ($urandom_range(0, 7) == 0) ? 1020 : int'($urandom_range(0, 70));
      sc_gy[i] = $urandom_range(0, 50);
      sc_v[i]  = 1'($urandom);
    end
    sc_bx = int'($urandom_range(0, 85)) - 10;
    sc_by = int'($urandom_range(0, 65)) - 10;
  endtask

  initial begin
    clearScene();
    resetDut(10);

    // single pipe with its gap, bird off screen
    clearScene();
    sc_v[0] = 1'b1; sc_px[0] = 10; sc_gy[0] = 20;
    runCycles(FT);

    // bird overlapping a pipe at the top-left corner
    clearScene();
    sc_v[0] = 1'b1; sc_px[0] = 0; sc_gy[0] = 30;
    sc_bx = 2; sc_by = 2;
    runCycles(FT);

    // bird wholly off the top-left, then partly clipped at the left edge
    clearScene();
    sc_bx = -8; sc_by = -8;
    runCycles(FT);
    clearScene();
    sc_bx = -1; sc_by = 24;
    runCycles(FT);

    // pipe whose right edge would wrap past 1023, gap reaching below the screen,
    // and a pipe running off the right edge
    clearScene();
    sc_v[0] = 1'b1; sc_px[0] = 1020; sc_gy[0] = 10;
    sc_v[1] = 1'b1; sc_px[1] = 5;    sc_gy[1] = 45;
    sc_v[2] = 1'b1; sc_px[2] = 60;   sc_gy[2] = 0;
    sc_bx = 62; sc_by = 30;
    runCycles(FT);

    for (int f = 0; f < 4; f++) begin
      randomScene();
      runCycles(FT);
    end

    $display("[TB] mid-frame reset");
    runCycles(1234);
    resetDut(3);
    for (int f = 0; f < 2; f++) begin
      randomScene();
      runCycles(FT);
    end
    runCycles(FT / 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
